mem_ref_sequencer: RTL and testbench

- Hardware control sequencer that drives the DataPath control strobes for instruction fetch and the memory-reference instructions ld, ldi and st.
- Adds parametrised RAM latency (wait-state counting), a hold/stall input, illegal-opcode fault detection and a done handshake.
- Sits between the future full control unit and DataPath. It connects to the same strobe names the DataPath already exposes.

---
 rtl/mem_ref_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_mem_ref_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ref_sequencer.sv
// Control sequencer for instruction fetch and the ld/ldi/st memory-reference
// instructions, with RAM wait states, stall input, illegal-opcode fault and done pulse.
module mem_ref_sequencer #(
  parameter int         MEM_LATENCY = 1,
  parameter int         CNT_W       = 4,
  parameter logic [4:0] ADD_OP      = 5'b00011,
  parameter logic [4:0] OP_LD       = 5'b00000,
  parameter logic [4:0] OP_LDI      = 5'b00001,
  parameter logic [4:0] OP_ST       = 5'b00010
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       start,
  input  logic       hold,
  input  logic [4:0] ir_opcode,
  output logic       PCout,
  output logic       IncPC,
  output logic       MARin,
  output logic       MDRin,
  output logic       IRin,
  output logic       MDRout,
  output logic       read,
  output logic       write,
  output logic       RAMenable,
  output logic       Gra,
  output logic       Grb,
  output logic       Rin,
  output logic       Rout,
  output logic       BAout,
  output logic       Yin,
  output logic       Cout,
  output logic       ZLOout,
  output logic [4:0] aluControl,
  output logic [3:0] step,
  output logic       done,
  output logic       fault
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_DONE  = 4'd9,
    S_FAULT = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    K_LD  = 2'd0,
    K_LDI = 2'd1,
    K_ST  = 2'd2
  } kind_t;

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

  state_t           state_q, state_d;
  kind_t            kind_q, kind_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic  op_legal;
  kind_t op_kind;

  // Opcode classification is only consumed in T3; kind_q holds it afterwards.
  always_comb begin
    op_legal = 1'b1;
    op_kind  = K_LD;
    if (ir_opcode == OP_LD) begin
      op_kind = K_LD;
    end else if (ir_opcode == OP_LDI) begin
      op_kind = K_LDI;
    end else if (ir_opcode == OP_ST) begin
      op_kind = K_ST;
    end else begin
      op_legal = 1'b0;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0: begin
        state_d = S_T1;
        cnt_d   = LAT_M1;
      end
      S_T1: begin
        if (cnt_q == '0) state_d = S_T2;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        if (op_legal) begin
          kind_d  = op_kind;
          state_d = S_T4;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_T4: state_d = S_T5;
      S_T5: begin
        if (kind_q == K_LDI) begin
          state_d = S_DONE;
        end else begin
          state_d = S_T6;
          cnt_d   = LAT_M1;
        end
      end
      S_T6: begin
        if (kind_q == K_LD) begin
          if (cnt_q == '0) state_d = S_T7;
          else             cnt_d   = cnt_q - 1'b1;
        end else begin
          state_d = S_T7;
          cnt_d   = LAT_M1;
        end
      end
      S_T7: begin
        if (kind_q == K_ST) begin
          if (cnt_q == '0) state_d = S_DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = start ? S_T0 : S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // hold freezes state, counter and latched opcode kind together.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      kind_q  <= K_LD;
      cnt_q   <= '0;
    end else if (!hold) begin
      // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore decode of the registered state; T3 additionally qualifies on opcode legality.
  always_comb begin
    PCout      = 1'b0;
    IncPC      = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    MDRout     = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    RAMenable  = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    BAout      = 1'b0;
    Yin        = 1'b0;
    Cout       = 1'b0;
    ZLOout     = 1'b0;
    aluControl = 5'b0;
    done       = 1'b0;
    if (!hold) begin
      unique case (state_q)
        S_T0: begin
          PCout = 1'b1;
          MARin = 1'b1;
          IncPC = 1'b1;
        end
        S_T1: begin
          read      = 1'b1;
          RAMenable = 1'b1;
          MDRin     = 1'b1;
        end
        S_T2: begin
          MDRout = 1'b1;
          IRin   = 1'b1;
        end
        S_T3: begin
          Grb   = op_legal;
          BAout = op_legal;
          Yin   = op_legal;
        end
        S_T4: begin
          Cout       = 1'b1;
          aluControl = ADD_OP;
        end
        S_T5: begin
          ZLOout = 1'b1;
          if (kind_q == K_LDI) begin
            Gra = 1'b1;
            Rin = 1'b1;
          end else begin
            MARin = 1'b1;
          end
        end
        S_T6: begin
          MDRin = 1'b1;
          if (kind_q == K_LD) begin
            read      = 1'b1;
            RAMenable = 1'b1;
          end else begin
            Gra  = 1'b1;
            Rout = 1'b1;
          end
        end
        S_T7: begin
          if (kind_q == K_ST) begin
            write     = 1'b1;
            RAMenable = 1'b1;
          end else begin
            MDRout = 1'b1;
            Gra    = 1'b1;
            Rin    = 1'b1;
          end
        end
        S_DONE:  done = 1'b1;
        default: ;
      endcase
    end
  end

  assign step  = state_q;
  assign fault = (state_q == S_FAULT);

endmodule

// File: tb/tb_mem_ref_sequencer.sv
// Scoreboard bench for mem_ref_sequencer: three instances (latency 1, 3, 2) share
// clock/clear/hold/opcode; expected per-cycle outputs are queued and compared in order.
module tb_mem_ref_sequencer;

  localparam logic [4:0] OP_LD  = 5'b00000;
  localparam logic [4:0] OP_LDI = 5'b00001;
  localparam logic [4:0] OP_ST  = 5'b00010;
  localparam logic [4:0] OP_BAD = 5'b10101;
  localparam logic [4:0] ADD    = 5'b00011;

  // Strobe bit positions, MSB first: PCout..ZLOout.
  localparam logic [16:0] PCO  = 17'd1 << 16;
  localparam logic [16:0] INC  = 17'd1 << 15;
  localparam logic [16:0] MAR  = 17'd1 << 14;
  localparam logic [16:0] MDRI = 17'd1 << 13;
  localparam logic [16:0] IRI  = 17'd1 << 12;
  localparam logic [16:0] MDRO = 17'd1 << 11;
  localparam logic [16:0] RD   = 17'd1 << 10;
  localparam logic [16:0] WR   = 17'd1 << 9;
  localparam logic [16:0] RAM  = 17'd1 << 8;
  localparam logic [16:0] GRA  = 17'd1 << 7;
  localparam logic [16:0] GRB  = 17'd1 << 6;
  localparam logic [16:0] RIN  = 17'd1 << 5;
  localparam logic [16:0] ROUT = 17'd1 << 4;
  localparam logic [16:0] BAO  = 17'd1 << 3;
  localparam logic [16:0] YIN  = 17'd1 << 2;
  localparam logic [16:0] COUT = 17'd1 << 1;
  localparam logic [16:0] ZLO  = 17'd1 << 0;

  typedef struct packed {
    logic [3:0]  step;
    logic [16:0] strb;
    logic [4:0]  alu;
    logic        done;
    logic        fault;
  } exp_t;

  logic       clock;
  logic       clear;
  logic       start;
  logic       hold;
  logic [4:0] ir_opcode;
  logic [1:0] sel;
  exp_t       obs [3];
  exp_t       exp_q [$];
  int         total;
  int         passed;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       pc, inc, mar, mdri, iri, mdro, rd, wr, ram;
    logic       gra, grb, rin, rout, bao, yin, cout, zlo;
    logic [4:0] alu;
    logic [3:0] stp;
    logic       dn, flt;

    mem_ref_sequencer #(
      .MEM_LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 2))
    ) u_dut (
      .clock     (clock),
      .clear     (clear),
      .start     (start && (sel == 2'(g))),
      .hold      (hold),
      .ir_opcode (ir_opcode),
      .PCout     (pc),
      .IncPC     (inc),
      .MARin     (mar),
      .MDRin     (mdri),
      .IRin      (iri),
      .MDRout    (mdro),
      .read      (rd),
      .write     (wr),
      .RAMenable (ram),
      .Gra       (gra),
      .Grb       (grb),
      .Rin       (rin),
      .Rout      (rout),
      .BAout     (bao),
      .Yin       (yin),
      .Cout      (cout),
      .ZLOout    (zlo),
      .aluControl(alu),
      .step      (stp),
      .done      (dn),
      .fault     (flt)
    );

    assign obs[g] = {stp, pc, inc, mar, mdri, iri, mdro, rd, wr, ram,
                     gra, grb, rin, rout, bao, yin, cout, zlo, alu, dn, flt};
  end

  task automatic check(input string tag, input exp_t o, input exp_t e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: got step=%0d strb=%05h alu=%02h done=%b fault=%b, expected step=%0d strb=%05h alu=%02h done=%b fault=%b",
                tag, o.step, o.strb, o.alu, o.done, o.fault, e.step, e.strb, e.alu, e.done, e.fault);
  endtask

  task automatic push(input logic [3:0] s, input logic [16:0] m, input logic [4:0] a,
                      input logic d, input logic f, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({s, m, a, d, f});
  endtask

  // Expected trace from T0 through DONE (or FAULT); hold_n frozen cycles inserted
  // after hold_at cycles of the fetch read.
  task automatic push_instr(input logic [4:0] op, input int lat, input int hold_at, input int hold_n);
    push(4'd1, PCO | MAR | INC, 5'd0, 1'b0, 1'b0, 1);
    push(4'd2, RD | RAM | MDRI, 5'd0, 1'b0, 1'b0, hold_at);
    push(4'd2, 17'd0,           5'd0, 1'b0, 1'b0, hold_n);
    push(4'd2, RD | RAM | MDRI, 5'd0, 1'b0, 1'b0, lat - hold_at);
    push(4'd3, MDRO | IRI,      5'd0, 1'b0, 1'b0, 1);
    if (op != OP_LD && op != OP_LDI && op != OP_ST) begin
      push(4'd4,  17'd0, 5'd0, 1'b0, 1'b0, 1);
      push(4'd10, 17'd0, 5'd0, 1'b0, 1'b1, 1);
    end else begin
      push(4'd4, GRB | BAO | YIN, 5'd0, 1'b0, 1'b0, 1);
      push(4'd5, COUT,            ADD,  1'b0, 1'b0, 1);
      if (op == OP_LDI) begin
        push(4'd6, ZLO | GRA | RIN, 5'd0, 1'b0, 1'b0, 1);
      end else if (op == OP_LD) begin
        push(4'd6, ZLO | MAR,        5'd0, 1'b0, 1'b0, 1);
        push(4'd7, RD | RAM | MDRI,  5'd0, 1'b0, 1'b0, lat);
        push(4'd8, MDRO | GRA | RIN, 5'd0, 1'b0, 1'b0, 1);
      end else begin
        push(4'd6, ZLO | MAR,         5'd0, 1'b0, 1'b0, 1);
        push(4'd7, GRA | ROUT | MDRI, 5'd0, 1'b0, 1'b0, 1);
        push(4'd8, WR | RAM,          5'd0, 1'b0, 1'b0, lat);
      end
      push(4'd9, 17'd0, 5'd0, 1'b1, 1'b0, 1);
    end
  endtask

  task automatic push_idle(input int n);
    push(4'd0, 17'd0, 5'd0, 1'b0, 1'b0, n);
  endtask

  // Compare the current cycle (inputs already driven) then advance one clock.
  task automatic tick(input string tag);
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      total++;
      $error("FAIL %s: got an extra cycle, expected queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs[sel], e);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) tick(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected completion within 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total     = 0;
    passed    = 0;
    clear     = 1'b0;
    start     = 1'b0;
    hold      = 1'b0;
    ir_opcode = OP_LD;
    sel       = 2'd0;
    #1 clear = 1'b1;
    #2;
    check("reset_l1", obs[0], '0);
    check("reset_l3", obs[1], '0);
    check("reset_l2", obs[2], '0);
    @(posedge clock);
    #1 clear = 1'b0;

    // ld, latency 1; opcode changed after T3 must not alter the sequence.
    sel = 2'd0;
    ir_opcode = OP_LD;
    push_idle(1);
    push_instr(OP_LD, 1, 0, 0);
    push_idle(1);
    start = 1'b1;
    tick("ld_l1");
    start = 1'b0;
    repeat (4) tick("ld_l1");
    ir_opcode = OP_LDI;
    drain("ld_l1");

    // st, latency 3.
    sel = 2'd1;
    ir_opcode = OP_ST;
    push_idle(1);
    push_instr(OP_ST, 3, 0, 0);
    push_idle(1);
    start = 1'b1;
    tick("st_l3");
    start = 1'b0;
    drain("st_l3");

    // ldi, latency 2; start held into T0/T1 is ignored.
    sel = 2'd2;
    ir_opcode = OP_LDI;
    push_idle(1);
    push_instr(OP_LDI, 2, 0, 0);
    push_idle(1);
    start = 1'b1;
    repeat (4) tick("ldi_l2");
    start = 1'b0;
    drain("ldi_l2");

    // Illegal opcode: FAULT is absorbing under repeated start pulses.
    sel = 2'd0;
    ir_opcode = OP_BAD;
    push_idle(1);
    push_instr(OP_BAD, 1, 0, 0);
    push(4'd10, 17'd0, 5'd0, 1'b0, 1'b1, 4);
    start = 1'b1;
    tick("fault");
    start = 1'b0;
    while (exp_q.size() > 0) begin
      start = ~start;
      tick("fault");
    end
    start = 1'b0;
    #2 clear = 1'b1;
    #1 check("fault_clear", obs[0], '0);
    clear = 1'b0;
    @(posedge clock);
    #1;
    push_idle(1);
    tick("fault_idle");

    // Stall for two cycles inside the latency-3 fetch read.
    sel = 2'd1;
    ir_opcode = OP_LD;
    push_idle(1);
    push_instr(OP_LD, 3, 1, 2);
    push_idle(1);
    start = 1'b1;
    tick("hold_ld");
    start = 1'b0;
    repeat (2) tick("hold_ld");
    hold = 1'b1;
    repeat (2) tick("hold_ld");
    hold = 1'b0;
    drain("hold_ld");

    // Asynchronous clear in T6 of ld, then back-to-back ldi with start held through DONE.
    sel = 2'd0;
    ir_opcode = OP_LD;
    push_idle(1);
    push_instr(OP_LD, 1, 0, 0);
    start = 1'b1;
    tick("clr_t6");
    start = 1'b0;
    repeat (6) tick("clr_t6");
    #2 clear = 1'b1;
    #1 check("clr_t6_async", obs[0], '0);
    exp_q.delete();
    #1 clear = 1'b0;
    @(posedge clock);
    #1;
    ir_opcode = OP_LDI;
    push_idle(1);
    push_instr(OP_LDI, 1, 0, 0);
    push_instr(OP_LDI, 1, 0, 0);
    push_idle(1);
    start = 1'b1;
    repeat (9) tick("b2b_ldi");
    start = 1'b0;
    drain("b2b_ldi");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
